// File: rtl/simple_fixed_2_pipe.sv
// Shift/rotate execution pipe for the SPU even pipeline.
// Computes halfword/word shift, rotate and rotate-and-mask results from
// register or 7-bit immediate counts. Results then pass through DEPTH staging
// registers that can be stalled. Every stage is exported for forwarding, and
// stage WB_STAGE drives register-file write back.
// Vectors use big-endian numbering (bit 0 = MSB). Element arithmetic works on
// an ordinary descending copy of each operand, which has the same numeric value.
module simple_fixed_2_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 4,
  parameter int WB_STAGE   = 2
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  stall,
  input  logic [0:10]                           op_code,
  input  logic [2:0]                            instr_format,
  input  logic [0:ADDR_WIDTH-1]                 dest_reg_addr,
  input  logic [0:DATA_WIDTH-1]                 src_reg_a,
  input  logic [0:DATA_WIDTH-1]                 src_reg_b,
  input  logic [0:17]                           imm_value,
  input  logic                                  enable_reg_write,
  input  logic                                  branch_is_taken,
  output logic [0:DATA_WIDTH-1]                 wb_data,
  output logic [0:ADDR_WIDTH-1]                 wb_reg_addr,
  output logic                                  wb_enable_reg_write,
  output logic [DEPTH-1:0][0:DATA_WIDTH-1]      delayed_rt_data,
  output logic [DEPTH-1:0][0:ADDR_WIDTH-1]      delayed_rt_addr,
  output logic [DEPTH-1:0]                      delayed_enable_reg_write
);

  localparam int NUM_HW = DATA_WIDTH / 16;
  localparam int NUM_WD = DATA_WIDTH / 32;

  // The low two opcode bits select the operation kind in both the halfword
  // and the word groups.
  typedef enum logic [1:0] {
    K_ROT   = 2'b00,
    K_ROTM  = 2'b01,
    K_ROTMA = 2'b10,
    K_SHL   = 2'b11
  } kind_t;

  // Halfword operation with a 7-bit raw count.
  function automatic logic [15:0] hw_op(input kind_t kind, input logic [15:0] a,
                                        input logic [6:0] c);
    logic [6:0]  s;
    logic [6:0]  amt;
    logic [31:0] rot;
    logic [15:0] r;
    s   = c & 7'h1F;
    amt = (7'd0 - c) & 7'h1F;
    rot = {a, a} << c[3:0];
    r   = 16'd0;
    case (kind)
      K_SHL:   r = (s >= 7'd16) ? 16'd0 : (a << s);
      K_ROT:   r = rot[31:16];
      K_ROTM:  r = (amt >= 7'd16) ? 16'd0 : (a >> amt);
      K_ROTMA: r = (amt >= 7'd16) ? {16{a[15]}} : 16'($signed(a) >>> amt);
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  // Word operation with a 7-bit raw count.
  function automatic logic [31:0] wd_op(input kind_t kind, input logic [31:0] a,
                                        input logic [6:0] c);
    logic [6:0]  s;
    logic [6:0]  amt;
    logic [63:0] rot;
    logic [31:0] r;
    s   = c & 7'h3F;
    amt = (7'd0 - c) & 7'h3F;
    rot = {a, a} << c[4:0];
    r   = 32'd0;
    case (kind)
      K_SHL:   r = (s >= 7'd32) ? 32'd0 : (a << s);
      K_ROT:   r = rot[63:32];
      K_ROTM:  r = (amt >= 7'd32) ? 32'd0 : (a >> amt);
      K_ROTMA: r = (amt >= 7'd32) ? {32{a[31]}} : 32'($signed(a) >>> amt);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] a_flat;
  logic [DATA_WIDTH-1:0] b_flat;
  logic [DATA_WIDTH-1:0] res_hw;
  logic [DATA_WIDTH-1:0] res_wd;
  logic [0:DATA_WIDTH-1] result;
  logic [6:0]            imm_cnt;
  logic                  supported;
  logic                  is_hw;
  logic                  is_imm;
  kind_t                 kind;
  logic                  bubble;
  logic                  unused_bits;

  assign a_flat  = src_reg_a;
  assign b_flat  = src_reg_b;
  assign imm_cnt = imm_value[11:17];

  // Only the low 7 count bits matter; upper immediate and rb bits are ignored.
  assign unused_bits = ^{imm_value[0:10], src_reg_b};

  // Opcode decode: element size, count source and operation kind.
  always_comb begin
    supported = 1'b1;
    is_hw     = 1'b0;
    is_imm    = 1'b0;
    kind      = K_ROT;
    case (op_code)
      11'b00001011111: begin is_hw = 1'b1;                 kind = K_SHL;   end
      11'b00001011100: begin is_hw = 1'b1;                 kind = K_ROT;   end
      11'b00001011101: begin is_hw = 1'b1;                 kind = K_ROTM;  end
      11'b00001011110: begin is_hw = 1'b1;                 kind = K_ROTMA; end
      11'b00001111111: begin is_hw = 1'b1; is_imm = 1'b1;  kind = K_SHL;   end
      11'b00001111100: begin is_hw = 1'b1; is_imm = 1'b1;  kind = K_ROT;   end
      11'b00001111101: begin is_hw = 1'b1; is_imm = 1'b1;  kind = K_ROTM;  end
      11'b00001111110: begin is_hw = 1'b1; is_imm = 1'b1;  kind = K_ROTMA; end
      11'b00001011011: begin                               kind = K_SHL;   end
      11'b00001011000: begin                               kind = K_ROT;   end
      11'b00001011001: begin                               kind = K_ROTM;  end
      11'b00001011010: begin                               kind = K_ROTMA; end
      11'b00001111011: begin is_imm = 1'b1;                kind = K_SHL;   end
      11'b00001111000: begin is_imm = 1'b1;                kind = K_ROT;   end
      11'b00001111001: begin is_imm = 1'b1;                kind = K_ROTM;  end
      11'b00001111010: begin is_imm = 1'b1;                kind = K_ROTMA; end
      default:         supported = 1'b0;
    endcase
  end

  // Per-element datapath for both element sizes; decode picks one.
  always_comb begin
    res_hw = '0;
    res_wd = '0;
    for (int i = 0; i < NUM_HW; i++) begin
      res_hw[16*i +: 16] = hw_op(kind, a_flat[16*i +: 16],
                                 is_imm ? imm_cnt : b_flat[16*i +: 7]);
    end
    for (int j = 0; j < NUM_WD; j++) begin
      res_wd[32*j +: 32] = wd_op(kind, a_flat[32*j +: 32],
                                 is_imm ? imm_cnt : b_flat[32*j +: 7]);
    end
    result = is_hw ? res_hw : res_wd;
  end

  // Nops, other formats, unsupported opcodes and killed instructions all
  // enter the pipe as an all-zero bubble.
  assign bubble = (instr_format != 3'd0) || branch_is_taken || !supported;

  // Staging pipeline: stage 0 captures the issue slot, later stages shift.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delayed_rt_data          <= '0;
      delayed_rt_addr          <= '0;
      delayed_enable_reg_write <= '0;
    end else if (!stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        delayed_rt_data[k]          <= delayed_rt_data[k-1];
        delayed_rt_addr[k]          <= delayed_rt_addr[k-1];
        delayed_enable_reg_write[k] <= delayed_enable_reg_write[k-1];
      end
      if (bubble) begin
        delayed_rt_data[0]          <= '0;
        delayed_rt_addr[0]          <= '0;
        delayed_enable_reg_write[0] <= 1'b0;
      end else begin
        delayed_rt_data[0]          <= result;
        delayed_rt_addr[0]          <= dest_reg_addr;
        delayed_enable_reg_write[0] <= enable_reg_write;
      end
    end
  end

  assign wb_data             = delayed_rt_data[WB_STAGE];
  assign wb_reg_addr         = delayed_rt_addr[WB_STAGE];
  assign wb_enable_reg_write = delayed_enable_reg_write[WB_STAGE];

endmodule

// File: tb/tb_simple_fixed_2_pipe.sv
// Directed bench for simple_fixed_2_pipe: default instance plus a
// 64-bit / depth-6 / write-back-stage-4 instance.
module tb_simple_fixed_2_pipe;

  localparam logic [10:0] OP_SHLH    = 11'b00001011111;
  localparam logic [10:0] OP_ROTMAH  = 11'b00001011110;
  localparam logic [10:0] OP_SHLHI   = 11'b00001111111;
  localparam logic [10:0] OP_ROTHI   = 11'b00001111100;
  localparam logic [10:0] OP_ROTHMI  = 11'b00001111101;
  localparam logic [10:0] OP_ROTMAHI = 11'b00001111110;
  localparam logic [10:0] OP_SHL     = 11'b00001011011;
  localparam logic [10:0] OP_ROT     = 11'b00001011000;
  localparam logic [10:0] OP_ROTMA   = 11'b00001011010;
  localparam logic [10:0] OP_SHLI    = 11'b00001111011;
  localparam logic [10:0] OP_ROTI    = 11'b00001111000;
  localparam logic [10:0] OP_ROTMI   = 11'b00001111001;
  localparam logic [10:0] OP_ROTMAI  = 11'b00001111010;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  // default instance signals
  logic                   stall;
  logic [0:10]            op_code;
  logic [2:0]             instr_format;
  logic [0:6]             dest_reg_addr;
  logic [0:127]           src_reg_a, src_reg_b;
  logic [0:17]            imm_value;
  logic                   enable_reg_write, branch_is_taken;
  logic [0:127]           wb_data;
  logic [0:6]             wb_reg_addr;
  logic                   wb_en;
  logic [3:0][0:127]      d_data;
  logic [3:0][0:6]        d_addr;
  logic [3:0]             d_we;

  // small instance signals
  logic                   stall2;
  logic [0:10]            op2;
  logic [2:0]             fmt2;
  logic [0:6]             addr2;
  logic [0:63]            a2, b2;
  logic [0:17]            imm2;
  logic                   we2, br2;
  logic [0:63]            wb_data2;
  logic [0:6]             wb_addr2;
  logic                   wb_en2;
  logic [5:0][0:63]       d_data2;
  logic [5:0][0:6]        d_addr2;
  logic [5:0]             d_we2;

  simple_fixed_2_pipe dut (
    .clock(clock), .reset(reset), .stall(stall), .op_code(op_code),
    .instr_format(instr_format), .dest_reg_addr(dest_reg_addr),
    .src_reg_a(src_reg_a), .src_reg_b(src_reg_b), .imm_value(imm_value),
    .enable_reg_write(enable_reg_write), .branch_is_taken(branch_is_taken),
    .wb_data(wb_data), .wb_reg_addr(wb_reg_addr), .wb_enable_reg_write(wb_en),
    .delayed_rt_data(d_data), .delayed_rt_addr(d_addr),
    .delayed_enable_reg_write(d_we)
  );

  simple_fixed_2_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(7), .DEPTH(6), .WB_STAGE(4)) dut2 (
    .clock(clock), .reset(reset), .stall(stall2), .op_code(op2),
    .instr_format(fmt2), .dest_reg_addr(addr2),
    .src_reg_a(a2), .src_reg_b(b2), .imm_value(imm2),
    .enable_reg_write(we2), .branch_is_taken(br2),
    .wb_data(wb_data2), .wb_reg_addr(wb_addr2), .wb_enable_reg_write(wb_en2),
    .delayed_rt_data(d_data2), .delayed_rt_addr(d_addr2),
    .delayed_enable_reg_write(d_we2)
  );

  // Drive one issue slot and advance one rising edge; returns 1 time unit after it.
  task automatic issue(input logic [10:0] op, input logic [2:0] fmt,
                       input logic [127:0] a, input logic [127:0] b,
                       input logic [17:0] imm, input logic [6:0] addr,
                       input logic we, input logic br, input logic st);
    op_code = op; instr_format = fmt; src_reg_a = a; src_reg_b = b;
    imm_value = imm; dest_reg_addr = addr; enable_reg_write = we;
    branch_is_taken = br; stall = st;
    @(posedge clock); #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++)
      issue(11'd0, 3'd0, 128'd0, 128'd0, 18'd0, 7'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #12;
    checks++;
    if (d_data !== '0 || d_addr !== '0 || d_we !== '0) begin
      failures++; $display("FAIL reset_init got_we=%b exp=0", d_we);
    end
    checks++;
    if (wb_data !== '0 || wb_reg_addr !== '0 || wb_en !== 1'b0) begin
      failures++; $display("FAIL reset_init_wb got=%h exp=0", wb_data);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    // three shl ops, then a reset between edges
    issue(OP_SHL, 3'd0, {4{32'h1}}, {4{32'd1}}, 18'd0, 7'd5, 1'b1, 1'b0, 1'b0);
    issue(OP_SHL, 3'd0, {4{32'h1}}, {4{32'd2}}, 18'd0, 7'd6, 1'b1, 1'b0, 1'b0);
    issue(OP_SHL, 3'd0, {4{32'h1}}, {4{32'd3}}, 18'd0, 7'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_we !== 4'b0111 || wb_reg_addr !== 7'd5 || d_data[0] !== {4{32'h8}}) begin
      failures++; $display("FAIL pre_reset_fill got_we=%b got_addr=%h exp_we=0111 exp_addr=05", d_we, wb_reg_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (d_data !== '0 || d_addr !== '0 || d_we !== '0) begin
      failures++; $display("FAIL reset_mid got_we=%b exp=0", d_we);
    end
    checks++;
    if (wb_data !== '0 || wb_reg_addr !== '0 || wb_en !== 1'b0) begin
      failures++; $display("FAIL reset_mid_wb got=%h exp=0", wb_data);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_shlh_latency;
    logic [127:0] exp_v;
    exp_v = {16'h0002, 16'h8000, 16'h0000, 16'h0000, 16'h0002, 16'h8000, 16'h0000, 16'h0000};
    step(4);
    issue(OP_SHLH, 3'd0, {8{16'h8001}},
          {16'd1, 16'd15, 16'd16, 16'd31, 16'd1, 16'd15, 16'd16, 16'd31},
          18'd0, 7'h11, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== exp_v) begin
      failures++; $display("FAIL shlh_data got=%h exp=%h", d_data[0], exp_v);
    end
    checks++;
    if (wb_en !== 1'b0) begin failures++; $display("FAIL shlh_wb_edge1 got=%b exp=0", wb_en); end
    step(1);
    checks++;
    if (wb_en !== 1'b0) begin failures++; $display("FAIL shlh_wb_edge2 got=%b exp=0", wb_en); end
    step(1);
    checks++;
    if (wb_en !== 1'b1 || wb_reg_addr !== 7'h11 || wb_data !== exp_v) begin
      failures++; $display("FAIL shlh_wb_edge3 got_en=%b got_addr=%h got=%h exp=%h", wb_en, wb_reg_addr, wb_data, exp_v);
    end
  endtask

  task automatic test_rotate;
    issue(OP_ROT, 3'd0, {4{32'h80000001}}, {32'd1, 32'd33, 32'd1, 32'd33},
          18'd0, 7'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {4{32'h00000003}}) begin
      failures++; $display("FAIL rot_reg got=%h exp=%h", d_data[0], {4{32'h00000003}});
    end
    issue(OP_ROTI, 3'd0, {4{32'h80000001}}, 128'd0, 18'd1, 7'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {4{32'h00000003}}) begin
      failures++; $display("FAIL roti_1 got=%h exp=%h", d_data[0], {4{32'h00000003}});
    end
    issue(OP_ROTI, 3'd0, {4{32'h80000001}}, 128'd0, 18'd33, 7'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {4{32'h00000003}}) begin
      failures++; $display("FAIL roti_33 got=%h exp=%h", d_data[0], {4{32'h00000003}});
    end
    issue(OP_ROTHI, 3'd0, {8{16'h8001}}, 128'd0, 18'd1, 7'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {8{16'h0003}}) begin
      failures++; $display("FAIL rothi_1 got=%h exp=%h", d_data[0], {8{16'h0003}});
    end
  endtask

  task automatic test_shift_mask;
    issue(OP_ROTMA, 3'd0, {4{32'h80000000}},
          {32'hFFFFFFFC, 32'hFFFFFFD8, 32'hFFFFFFFC, 32'hFFFFFFD8},
          18'd0, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {32'hF8000000, 32'hFFFFFFFF, 32'hF8000000, 32'hFFFFFFFF}) begin
      failures++; $display("FAIL rotma_reg got=%h", d_data[0]);
    end
    issue(OP_ROTMAI, 3'd0, {4{32'h80000000}}, 128'd0, 18'h0007C, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {4{32'hF8000000}}) begin
      failures++; $display("FAIL rotmai_m4 got=%h exp=%h", d_data[0], {4{32'hF8000000}});
    end
    issue(OP_ROTMAI, 3'd0, {4{32'h80000000}}, 128'd0, 18'h00058, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {4{32'hFFFFFFFF}}) begin
      failures++; $display("FAIL rotmai_m40 got=%h exp=%h", d_data[0], {4{32'hFFFFFFFF}});
    end
    issue(OP_ROTMI, 3'd0, {4{32'h80000000}}, 128'd0, 18'h0007C, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {4{32'h08000000}}) begin
      failures++; $display("FAIL rotmi_m4 got=%h exp=%h", d_data[0], {4{32'h08000000}});
    end
    issue(OP_ROTMAHI, 3'd0, {8{16'h8000}}, 128'd0, 18'h0007C, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {8{16'hF800}}) begin
      failures++; $display("FAIL rotmahi_m4 got=%h exp=%h", d_data[0], {8{16'hF800}});
    end
    issue(OP_ROTHMI, 3'd0, {8{16'h8000}}, 128'd0, 18'h0007C, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {8{16'h0800}}) begin
      failures++; $display("FAIL rothmi_m4 got=%h exp=%h", d_data[0], {8{16'h0800}});
    end
    issue(OP_ROTMAH, 3'd0, {8{16'h8000}},
          {2{16'hFFF0, 16'hFFF1, 16'hFFFF, 16'h0000}}, 18'd0, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {2{16'hFFFF, 16'hFFFF, 16'hC000, 16'h8000}}) begin
      failures++; $display("FAIL rotmah_reg got=%h", d_data[0]);
    end
    issue(OP_SHL, 3'd0, {4{32'h1}}, {32'd31, 32'd32, 32'd63, 32'd64},
          18'd0, 7'd2, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== {32'h80000000, 32'h0, 32'h0, 32'h1}) begin
      failures++; $display("FAIL shl_bounds got=%h", d_data[0]);
    end
  endtask

  task automatic test_bubbles;
    issue(OP_SHLI, 3'd3, {4{32'h1}}, 128'd0, 18'd1, 7'd9, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== '0 || d_addr[0] !== 7'd0 || d_we[0] !== 1'b0) begin
      failures++; $display("FAIL bubble_format got=%h exp=0", d_data[0]);
    end
    issue(11'h7FF, 3'd0, {4{32'h1}}, 128'd0, 18'd1, 7'd9, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_data[0] !== '0 || d_addr[0] !== 7'd0 || d_we[0] !== 1'b0) begin
      failures++; $display("FAIL bubble_unsupported got=%h exp=0", d_data[0]);
    end
    issue(11'd0, 3'd0, {4{32'h1}}, 128'd0, 18'd1, 7'd9, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_addr[0] !== 7'd0 || d_we[0] !== 1'b0) begin
      failures++; $display("FAIL bubble_nop got_we=%b exp=0", d_we[0]);
    end
  endtask

  task automatic test_branch;
    step(4);
    issue(OP_SHLI, 3'd0, {4{32'h1}}, 128'd0, 18'd4, 7'd1, 1'b1, 1'b0, 1'b0);
    issue(OP_SHLI, 3'd0, {4{32'h1}}, 128'd0, 18'd4, 7'd2, 1'b1, 1'b1, 1'b0);
    issue(OP_SHLI, 3'd0, {4{32'h1}}, 128'd0, 18'd4, 7'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_we !== 4'b0101) begin
      failures++; $display("FAIL branch_we got=%b exp=0101", d_we);
    end
    checks++;
    if (d_addr[1] !== 7'd0 || d_data[1] !== '0 || d_addr[2] !== 7'd1 || d_data[2] !== {4{32'h10}}) begin
      failures++; $display("FAIL branch_slots got_addr1=%h got_addr2=%h exp=00/01", d_addr[1], d_addr[2]);
    end
  endtask

  task automatic test_stall;
    step(4);
    issue(OP_SHLI, 3'd0, {4{32'h1}}, 128'd0, 18'd4, 7'd4, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      issue(OP_SHLI, 3'd0, {4{32'h1}}, 128'd0, 18'd2, 7'd6, 1'b1, 1'b1, 1'b1);
      checks++;
      if (d_we !== 4'b0001 || d_addr[0] !== 7'd4 || d_data[0] !== {4{32'h10}} || d_addr[1] !== 7'd0) begin
        failures++; $display("FAIL stall_hold cycle=%0d got_we=%b got_addr0=%h exp_we=0001 exp_addr0=04", s, d_we, d_addr[0]);
      end
    end
    issue(OP_SHLI, 3'd0, {4{32'h1}}, 128'd0, 18'd2, 7'd6, 1'b1, 1'b0, 1'b0);
    checks++;
    if (d_addr[0] !== 7'd6 || d_addr[1] !== 7'd4 || d_data[0] !== {4{32'h4}}) begin
      failures++; $display("FAIL stall_resume got_addr0=%h got_addr1=%h exp=06/04", d_addr[0], d_addr[1]);
    end
    step(1);
    checks++;
    if (wb_reg_addr !== 7'd4 || wb_en !== 1'b1) begin
      failures++; $display("FAIL stall_wb_a got=%h exp=04", wb_reg_addr);
    end
    step(1);
    checks++;
    if (wb_reg_addr !== 7'd6 || wb_en !== 1'b1 || wb_data !== {4{32'h4}}) begin
      failures++; $display("FAIL stall_wb_c got=%h exp=06", wb_reg_addr);
    end
  endtask

  task automatic test_param;
    logic [63:0] exp_v;
    exp_v = 64'h0008_0008_91A0_FFF8;
    op2 = OP_SHLHI; fmt2 = 3'd0; a2 = 64'h0001_8001_1234_FFFF; b2 = '0;
    imm2 = 18'd3; addr2 = 7'h2A; we2 = 1'b1; br2 = 1'b0;
    @(posedge clock); #1;
    op2 = '0; we2 = 1'b0; addr2 = '0; imm2 = '0; a2 = '0;
    checks++;
    if (d_data2[0] !== exp_v) begin
      failures++; $display("FAIL p_shlhi got=%h exp=%h", d_data2[0], exp_v);
    end
    for (int e = 2; e <= 4; e++) begin @(posedge clock); #1; end
    checks++;
    if (wb_en2 !== 1'b0) begin failures++; $display("FAIL p_wb_edge4 got=%b exp=0", wb_en2); end
    @(posedge clock); #1;
    checks++;
    if (wb_en2 !== 1'b1 || wb_addr2 !== 7'h2A || wb_data2 !== exp_v) begin
      failures++; $display("FAIL p_wb_edge5 got_en=%b got_addr=%h got=%h exp=%h", wb_en2, wb_addr2, wb_data2, exp_v);
    end
    @(posedge clock); #1;
    checks++;
    if (d_addr2[5] !== 7'h2A || d_we2[5] !== 1'b1 || wb_en2 !== 1'b0) begin
      failures++; $display("FAIL p_retire got_addr5=%h got_wb_en=%b exp=2a/0", d_addr2[5], wb_en2);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 0; op_code = '0; instr_format = '0; dest_reg_addr = '0;
    src_reg_a = '0; src_reg_b = '0; imm_value = '0;
    enable_reg_write = 0; branch_is_taken = 0;
    stall2 = 0; op2 = '0; fmt2 = '0; addr2 = '0; a2 = '0; b2 = '0;
    imm2 = '0; we2 = 0; br2 = 0;
    test_reset;
    test_shlh_latency;
    test_rotate;
    test_shift_mask;
    test_bubbles;
    test_branch;
    test_stall;
    test_param;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simple_fixed_2_pipe.md
# simple_fixed_2_pipe

Parametrised shift/rotate execution pipe for the SPU even pipeline, successor to the fixed 128-bit, four-stage shift/rotate unit. Computes halfword/word shift, rotate and rotate-and-mask (logical and arithmetic right shift) results from register or 7-bit immediate counts. Results travel through a configurable-depth staging pipeline with stall support. Every stage is exported for forwarding, and one selectable stage drives register-file write back.

## Interface
- DATA_WIDTH, 128: operand/result width; multiple of 32; big-endian numbering [0:DATA_WIDTH-1], bit 0 = MSB.
- ADDR_WIDTH, 7: register address width.
- DEPTH, 4: number of staging stages (>=2).
- WB_STAGE, 2: stage index driving write back (0 <= WB_STAGE < DEPTH).
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears every stage.
- stall  in  1  freeze all stages and ignore issue inputs this cycle.
- op_code  in  [0:10]  decoded opcode.
- instr_format  in  [2:0]  instruction format; only format 0 is executed here.
- dest_reg_addr  in  [0:ADDR_WIDTH-1]  destination register.
- src_reg_a, src_reg_b  in  [0:DATA_WIDTH-1]  source operands.
- imm_value  in  [0:17]  immediate; count = imm_value[11:17].
- enable_reg_write  in  1  instruction writes the register file.
- branch_is_taken  in  1  kill the instruction issuing this cycle.
- wb_data  out  [0:DATA_WIDTH-1]  = delayed_rt_data[WB_STAGE].
- wb_reg_addr  out  [0:ADDR_WIDTH-1]  = delayed_rt_addr[WB_STAGE].
- wb_enable_reg_write  out  1  = delayed_enable_reg_write[WB_STAGE].
- delayed_rt_data  out  [DEPTH-1:0][0:DATA_WIDTH-1]  per-stage results for forwarding.
- delayed_rt_addr  out  [DEPTH-1:0][0:ADDR_WIDTH-1]  per-stage destinations.
- delayed_enable_reg_write  out  [DEPTH-1:0]  per-stage write flags.

## Operation
- Supported ops, format 0, grouped by element size and count source:
  - Halfword, count from rb element: shlh 00001011111, roth 00001011100, rothm 00001011101, rotmah 00001011110.
  - Halfword, count from imm: shlhi 00001111111, rothi 00001111100, rothmi 00001111101, rotmahi 00001111110.
  - Word, count from rb element: shl 00001011011, rot 00001011000, rotm 00001011001, rotma 00001011010.
  - Word, count from imm: shli 00001111011, roti 00001111000, rotmi 00001111001, rotmai 00001111010.
- Per-element count: register forms use the low bits of the matching rb element; immediate forms use the 7-bit imm count.
- Shift left: halfword count = count & 0x1F, word count = count & 0x3F. Count >= element width gives 0.
- Rotate left: halfword count & 0xF, word count & 0x1F. Bits leaving the MSB re-enter at the LSB.
- Rotate-and-mask (right shift): amount = (-count) & 0x1F for halfword, & 0x3F for word.
  - Logical forms zero-fill; amount >= element width gives 0.
  - Arithmetic forms sign-fill; amount >= element width gives all sign bits.
- Bubble inserted into stage 0 (data 0, addr 0, we 0) when any of the following holds:
  - nop (format 0, op_code 0);
  - format != 0;
  - branch_is_taken = 1;
  - unsupported format-0 opcode.
- Otherwise stage 0 loads the computed result, dest_reg_addr and enable_reg_write.
- Each cycle without stall: stage k loads stage k-1 for k = 1..DEPTH-1; the last stage's contents are dropped.
- stall = 1: every stage holds its value; issue inputs are ignored, including branch_is_taken.

## Timing
- Reset (async assert, any time including mid-pipeline): all delayed_* = 0, so wb_* = 0 immediately. First capture happens on the first rising edge after deassert.
- Result computation is combinational into stage 0, registered on the issue edge.
- Write-back latency: WB_STAGE+1 non-stalled edges after issue.
- A result stays visible on delayed_* at stage k after k+1 non-stalled edges.
- wb_* are combinational copies of stage WB_STAGE; there is no extra register.
- Stalled cycles do not advance latency.
- Simultaneous branch_is_taken and a valid op: bubble. Simultaneous stall and branch_is_taken: stall wins; nothing is captured.

## Test plan
- Reset mid-stream: issue 3 shl ops, assert reset between edges → all delayed_* and wb_* = 0 without waiting for a clock edge.
- shlh, ra halfwords 0x8001, rb counts {1, 15, 16, 31} → 0x0002, 0x8000, 0x0000, 0x0000; wb_enable_reg_write = 1 exactly 3 edges after issue (DEPTH 4, WB_STAGE 2).
- rot and roti, ra word 0x80000001, count 1 → 0x00000003; count 33 → 0x00000003 (masked to 1).
- rotma and rotmai, ra word 0x80000000, count -4 (0x7C) → 0xF8000000; count -40 → 0xFFFFFFFF. rotm with count -4 → 0x08000000.
- Pipeline control with issue sequence A, B, C:
  - branch_is_taken with B → B's slot carries we = 0.
  - stall for 2 cycles with C waiting → all stages frozen; C reaches wb 2 cycles later than without the stall.
- Parameter sweep: DATA_WIDTH 64, DEPTH 6, WB_STAGE 4 → shlhi by 3 gives correct per-halfword results; write-back latency = 5 edges; delayed_rt_addr[5] holds the retired address one edge after write back.
